// File: rtl/a_buffer_loader.sv
// Streams a rows x depth tile from the global BRAM into the per-row activation RAMs.
// Reads are issued from registered outputs; the matching row write lands one cycle later with the BRAM data.
module a_buffer_loader #(
  parameter int ARRAY_N         = 8,
  parameter int ACT_WIDTH       = 8,
  parameter int RAM_SIZE        = 1024,
  parameter int ADDR_WIDTH      = $clog2(RAM_SIZE),
  parameter int BRAM_ADDR_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [BRAM_ADDR_WIDTH-1:0] cfg_bram_base,
  input  logic [ADDR_WIDTH-1:0]      cfg_buf_base,
  input  logic [$clog2(ARRAY_N):0]   cfg_num_rows,
  input  logic [ADDR_WIDTH:0]        cfg_depth,
  input  logic                       stall,
  output logic                       bram_rd_en,
  output logic [BRAM_ADDR_WIDTH-1:0] bram_rd_addr,
  input  logic [ACT_WIDTH-1:0]       bram_rd_data,
  output logic [ARRAY_N-1:0]         bram_to_ram_w_en,
  output logic [ADDR_WIDTH-1:0]      bram_to_ram_w_addr,
  output logic [ACT_WIDTH-1:0]       bram_to_ram_w_data,
  output logic                       busy,
  output logic                       done
);

  localparam int ROW_W = $clog2(ARRAY_N) + 1;
  localparam int DEP_W = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                     r_state;
  logic [ROW_W-1:0]           r_num_rows;
  logic [DEP_W-1:0]           r_depth;
  logic [ADDR_WIDTH-1:0]      r_buf_base;
  logic [ROW_W-1:0]           r_row;
  logic [DEP_W-1:0]           r_col;
  logic [BRAM_ADDR_WIDTH-1:0] r_ptr;
  logic                       r_all_issued;
  logic                       r_rd_en;
  logic [BRAM_ADDR_WIDTH-1:0] r_rd_addr;
  logic [ROW_W-1:0]           r_rd_row;
  logic [ADDR_WIDTH-1:0]      r_rd_col;
  logic [ARRAY_N-1:0]         r_w_en;
  logic [ADDR_WIDTH-1:0]      r_w_addr;
  logic                       r_busy;
  logic                       r_done;

  logic [ROW_W-1:0]           w_cfg_rows;
  logic                       w_start_ok;
  logic                       w_issue;
  logic [ROW_W-1:0]           w_cur_row;
  logic [DEP_W-1:0]           w_cur_col;
  logic [BRAM_ADDR_WIDTH-1:0] w_cur_ptr;
  logic [DEP_W-1:0]           w_cur_depth;
  logic [ROW_W-1:0]           w_cur_rows;
  logic                       w_last_col;
  logic                       w_last;
  logic [ROW_W-1:0]           w_next_row;
  logic [DEP_W-1:0]           w_next_col;

  // The first read is issued on the same edge that accepts start, so the
  // read cursor comes straight from the cfg inputs while still in IDLE.
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    w_cfg_rows  = '0;
    w_start_ok  = 1'b0;
    w_issue     = 1'b0;
    w_cur_row   = r_row;
    w_cur_col   = r_col;
    w_cur_ptr   = r_ptr;
    w_cur_depth = r_depth;
    w_cur_rows  = r_num_rows;
    w_last_col  = 1'b0;
    w_last      = 1'b0;
    w_next_row  = r_row;
    w_next_col  = r_col;

    w_cfg_rows = (cfg_num_rows > ROW_W'(ARRAY_N)) ? ROW_W'(ARRAY_N) : cfg_num_rows;
    w_start_ok = (r_state == S_IDLE) && start && (w_cfg_rows != '0) && (cfg_depth != '0);

    if (r_state == S_IDLE) begin
      w_cur_row   = '0;
      w_cur_col   = '0;
      w_cur_ptr   = cfg_bram_base;
      w_cur_depth = cfg_depth;
      w_cur_rows  = w_cfg_rows;
    end

    w_issue    = !stall && (w_start_ok || ((r_state == S_LOAD) && !r_all_issued));
    w_last_col = (w_cur_col == w_cur_depth - DEP_W'(1));
    w_last     = w_last_col && (w_cur_row == w_cur_rows - ROW_W'(1));
    w_next_col = w_last_col ? '0 : w_cur_col + DEP_W'(1);
    w_next_row = w_last_col ? w_cur_row + ROW_W'(1) : w_cur_row;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_num_rows   <= '0;
      r_depth      <= '0;
      r_buf_base   <= '0;
      r_row        <= '0;
      r_col        <= '0;
      r_ptr        <= '0;
      r_all_issued <= 1'b0;
      r_rd_en      <= 1'b0;
      r_rd_addr    <= '0;
      r_rd_row     <= '0;
      r_rd_col     <= '0;
      r_w_en       <= '0;
      r_w_addr     <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
      r_rd_en  <= w_issue;
      r_w_en   <= r_rd_en ? (ARRAY_N'(1) << r_rd_row) : '0;
      r_w_addr <= r_buf_base + r_rd_col;

      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_num_rows   <= w_cfg_rows;
            r_depth      <= cfg_depth;
            r_buf_base   <= cfg_buf_base;
            r_row        <= '0;
            r_col        <= '0;
            r_ptr        <= cfg_bram_base;
            r_all_issued <= 1'b0;
            r_busy       <= 1'b1;
            r_state      <= w_start_ok ? S_LOAD : S_DRAIN;
          end
        end
        S_LOAD: begin
          if (r_all_issued) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          r_state <= S_DONE;
          r_done  <= 1'b1;
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase

      // Placed after the case so an issue on the start edge overrides the cursor reset.
      if (w_issue) begin
        r_rd_addr    <= w_cur_ptr;
        r_rd_row     <= w_cur_row;
        r_rd_col     <= w_cur_col[ADDR_WIDTH-1:0];
        r_row        <= w_next_row;
        r_col        <= w_next_col;
        r_ptr        <= w_cur_ptr + BRAM_ADDR_WIDTH'(1);
        r_all_issued <= w_last;
      end
    end
  end

  assign bram_rd_en         = r_rd_en;
  assign bram_rd_addr       = r_rd_addr;
  assign bram_to_ram_w_en   = r_w_en;
  assign bram_to_ram_w_addr = r_w_addr;
  assign bram_to_ram_w_data = bram_rd_data;
  assign busy               = r_busy;
  assign done               = r_done;

endmodule

// File: tb/tb_a_buffer_loader.sv
// Bench for a_buffer_loader: directed table, reset-abort sequence and randomized
// runs checked cycle by cycle against a read/write timeline model.
module tb_a_buffer_loader;

  localparam int ARRAY_N         = 8;
  localparam int ACT_WIDTH       = 8;
  localparam int RAM_SIZE        = 1024;
  localparam int ADDR_WIDTH      = 10;
  localparam int BRAM_ADDR_WIDTH = 16;
  localparam int MAXC            = 300;

  logic                       clk = 1'b0;
  logic                       reset;
  logic                       start;
  logic [BRAM_ADDR_WIDTH-1:0] cfg_bram_base;
  logic [ADDR_WIDTH-1:0]      cfg_buf_base;
  logic [3:0]                 cfg_num_rows;
  logic [ADDR_WIDTH:0]        cfg_depth;
  logic                       stall;
  logic                       bram_rd_en;
  logic [BRAM_ADDR_WIDTH-1:0] bram_rd_addr;
  logic [ACT_WIDTH-1:0]       bram_rd_data;
  logic [ARRAY_N-1:0]         bram_to_ram_w_en;
  logic [ADDR_WIDTH-1:0]      bram_to_ram_w_addr;
  logic [ACT_WIDTH-1:0]       bram_to_ram_w_data;
  logic                       busy;
  logic                       done;

  always #5 clk = ~clk;

  a_buffer_loader #(
    .ARRAY_N(ARRAY_N), .ACT_WIDTH(ACT_WIDTH), .RAM_SIZE(RAM_SIZE),
    .ADDR_WIDTH(ADDR_WIDTH), .BRAM_ADDR_WIDTH(BRAM_ADDR_WIDTH)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .cfg_bram_base(cfg_bram_base), .cfg_buf_base(cfg_buf_base),
    .cfg_num_rows(cfg_num_rows), .cfg_depth(cfg_depth), .stall(stall),
    .bram_rd_en(bram_rd_en), .bram_rd_addr(bram_rd_addr), .bram_rd_data(bram_rd_data),
    .bram_to_ram_w_en(bram_to_ram_w_en), .bram_to_ram_w_addr(bram_to_ram_w_addr),
    .bram_to_ram_w_data(bram_to_ram_w_data), .busy(busy), .done(done)
  );

  // BRAM model: word at address a is a[7:0] ^ key, returned one cycle after the read strobe.
  logic [7:0] bram_key = 8'h00;
  function automatic logic [7:0] bram_word(logic [15:0] a);
    return a[7:0] ^ bram_key;
  endfunction
  always @(posedge clk) if (bram_rd_en) bram_rd_data <= bram_word(bram_rd_addr);

  int n_vec = 0;
  int n_err = 0;

  task automatic check(string name, int t, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got 0x%0h, want 0x%0h", name, t, act, exp);
    end
  endtask

  typedef struct {
    int          rows;
    int          depth;
    logic [15:0] bram_base;
    logic [9:0]  buf_base;
    logic [63:0] stall_mask;  // bit e: stall sampled at edge e (edge 0 samples start)
    bit          noise;       // extra start pulses while busy (must be ignored)
    int          exp_done;    // expected done cycle, or -1 when only the model decides
    string       name;
  } vec_t;

  // Expected per-cycle outputs; cycle c is the interval following edge c-1.
  logic        e_rd_en   [MAXC];
  logic [15:0] e_rd_addr [MAXC];
  logic [7:0]  e_w_en    [MAXC];
  logic [9:0]  e_w_addr  [MAXC];
  logic [7:0]  e_w_data  [MAXC];
  int          e_done;
  logic [9:0]  q_waddr[$];

  // Tile is read in linear order idx = r*depth + k; each unstalled edge issues the next one.
  task automatic build_model(vec_t v);
    int rows_eff, n, idx, last, row, col;
    for (int c = 0; c < MAXC; c++) begin
      e_rd_en[c] = 1'b0; e_rd_addr[c] = '0; e_w_en[c] = '0; e_w_addr[c] = '0; e_w_data[c] = '0;
    end
    rows_eff = (v.rows > ARRAY_N) ? ARRAY_N : v.rows;
    n = rows_eff * v.depth;
    idx = 0;
    last = 0;
    for (int e = 0; e < MAXC - 3 && idx < n; e++) begin
      if (e < 64 && v.stall_mask[e]) continue;
      row = idx / v.depth;
      col = idx % v.depth;
      e_rd_en[e+1]   = 1'b1;
      e_rd_addr[e+1] = 16'(int'(v.bram_base) + idx);
      e_w_en[e+2]    = 8'(1 << row);
      e_w_addr[e+2]  = 10'((int'(v.buf_base) + col) % RAM_SIZE);
      e_w_data[e+2]  = bram_word(e_rd_addr[e+1]);
      last = e + 1;
      idx++;
    end
    e_done = (n == 0) ? 2 : last + 2;
  endtask

  task automatic run_vec(vec_t v);
    int done_at;
    build_model(v);
    q_waddr.delete();
    done_at = -1;
    @(negedge clk);
    start         = 1'b1;
    cfg_bram_base = v.bram_base;
    cfg_buf_base  = v.buf_base;
    cfg_num_rows  = 4'(v.rows);
    cfg_depth     = 11'(v.depth);
    stall         = v.stall_mask[0];
    for (int t = 1; t <= e_done + 2; t++) begin
      @(negedge clk);
      check({v.name, ".rd_en"}, t, 32'(bram_rd_en), 32'(e_rd_en[t]));
      if (e_rd_en[t]) check({v.name, ".rd_addr"}, t, 32'(bram_rd_addr), 32'(e_rd_addr[t]));
      check({v.name, ".w_en"}, t, 32'(bram_to_ram_w_en), 32'(e_w_en[t]));
      if (e_w_en[t] != 0) begin
        check({v.name, ".w_addr"}, t, 32'(bram_to_ram_w_addr), 32'(e_w_addr[t]));
        check({v.name, ".w_data"}, t, 32'(bram_to_ram_w_data), 32'(e_w_data[t]));
      end
      check({v.name, ".busy"}, t, 32'(busy), 32'(t <= e_done));
      check({v.name, ".done"}, t, 32'(done), 32'(t == e_done));
      if (bram_to_ram_w_en != '0) q_waddr.push_back(bram_to_ram_w_addr);
      if (done === 1'b1 && done_at < 0) done_at = t;
      start = v.noise && (t < e_done) && (t == 1 || $urandom_range(0, 2) == 0);
      if (start) begin
        cfg_bram_base = 16'($urandom);
        cfg_buf_base  = 10'($urandom);
        cfg_num_rows  = 4'($urandom_range(1, 15));
        cfg_depth     = 11'($urandom_range(1, 9));
      end
      stall = (t < 64) ? v.stall_mask[t] : 1'b0;
    end
    start = 1'b0;
    stall = 1'b0;
    if (v.exp_done > 0) check({v.name, ".done_cycle"}, 0, 32'(done_at), 32'(v.exp_done));
  endtask

  task automatic check_outputs_zero(string name, int t);
    check({name, ".rd_en"},   t, 32'(bram_rd_en), 32'd0);
    check({name, ".rd_addr"}, t, 32'(bram_rd_addr), 32'd0);
    check({name, ".w_en"},    t, 32'(bram_to_ram_w_en), 32'd0);
    check({name, ".w_addr"},  t, 32'(bram_to_ram_w_addr), 32'd0);
    check({name, ".busy"},    t, 32'(busy), 32'd0);
    check({name, ".done"},    t, 32'(done), 32'd0);
  endtask

  vec_t tab[5];
  int   exp_wrap[4];

  initial begin
    reset = 1'b0; start = 1'b0; stall = 1'b0;
    cfg_bram_base = '0; cfg_buf_base = '0; cfg_num_rows = '0; cfg_depth = '0;

    tab[0] = '{rows: 2,  depth: 3, bram_base: 16'h0100, buf_base: 10'h010, stall_mask: 64'h0,
               noise: 1'b0, exp_done: 8,  name: "basic_2x3"};
    tab[1] = '{rows: 12, depth: 1, bram_base: 16'h0000, buf_base: 10'h000, stall_mask: 64'h0,
               noise: 1'b0, exp_done: 10, name: "clamp_rows"};
    tab[2] = '{rows: 2,  depth: 3, bram_base: 16'h0100, buf_base: 10'h010, stall_mask: 64'h6,
               noise: 1'b0, exp_done: 10, name: "stall_2_3"};
    tab[3] = '{rows: 2,  depth: 0, bram_base: 16'h0040, buf_base: 10'h005, stall_mask: 64'h0,
               noise: 1'b1, exp_done: 2,  name: "depth_zero"};
    tab[4] = '{rows: 1,  depth: 4, bram_base: 16'hFFFE, buf_base: 10'd1022, stall_mask: 64'h0,
               noise: 1'b0, exp_done: 6,  name: "buf_wrap"};
    exp_wrap = '{1022, 1023, 0, 1};

    repeat (2) @(negedge clk);
    check_outputs_zero("reset", 0);
    reset = 1'b1;

    for (int i = 0; i < 5; i++) run_vec(tab[i]);

    // Buffer address wrap, taken from the last table entry.
    check("wrap.count", 0, 32'(q_waddr.size()), 32'd4);
    for (int i = 0; i < 4 && i < q_waddr.size(); i++)
      check("wrap.addr", i, 32'(q_waddr[i]), 32'(exp_wrap[i]));

    // Reset asserted in cycle 4 of a 2x3 load: outputs clear at once, no done follows.
    @(negedge clk);
    start = 1'b1; cfg_bram_base = 16'h0100; cfg_buf_base = 10'h010;
    cfg_num_rows = 4'd2; cfg_depth = 11'd3; stall = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("abort.busy_before", 4, 32'(busy), 32'd1);
    check("abort.rd_addr_before", 4, 32'(bram_rd_addr), 32'h0103);
    #2 reset = 1'b0;
    #1 check_outputs_zero("abort", 4);
    for (int t = 5; t < 8; t++) begin
      @(negedge clk);
      check("abort.done", t, 32'(done), 32'd0);
      check("abort.busy", t, 32'(busy), 32'd0);
    end
    reset = 1'b1;
    run_vec(tab[0]);

    // Randomized tiles, stall patterns and ignored start pulses.
    for (int i = 0; i < 40; i++) begin
      vec_t v;
      v.rows       = $urandom_range(0, 15);
      v.depth      = $urandom_range(0, 8);
      v.bram_base  = 16'($urandom);
      v.buf_base   = 10'($urandom);
      v.stall_mask = {$urandom, $urandom} & {$urandom, $urandom};
      v.noise      = 1'b1;
      v.exp_done   = -1;
      v.name       = "rand";
      bram_key     = 8'($urandom);
      run_vec(v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
